// File: rtl/mips_defs.sv
// Shared encodings for the load/store path: request opcodes, FSM states and
// access sizes, plus small decode helpers used by the LSU.
package mips_defs;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } lsu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_RESP  = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_t;

   function automatic lsu_size_t op_size(input lsu_op_t op);
      lsu_size_t sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
         default:              sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic op_signed(input lsu_op_t op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

   function automatic logic op_is_store(input lsu_op_t op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   function automatic logic op_misaligned(input lsu_op_t op, input logic [1:0] lo);
      logic bad;
      case (op_size(op))
         SZ_WORD: bad = (lo != 2'b00);
         SZ_HALF: bad = lo[0];
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Byte-lane helper: extracts/extends a load lane and builds the merged word
// for a sub-word store. Purely combinational.
module lsu_lane_merge
   import mips_defs::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  byte_sel,
   input  lsu_size_t   size,
   input  logic        sign_ext,
   input  logic [31:0] store_data,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [7:0]  lane8_s;
   logic [15:0] lane16_s;

   // lane select, extension and store merge
   always_comb begin
      lane8_s    = word[{byte_sel, 3'b000} +: 8];
      lane16_s   = word[{byte_sel[1], 4'b0000} +: 16];
      load_val   = word;
      store_word = store_data;
      case (size)
         SZ_BYTE: begin
            load_val   = {{24{sign_ext & lane8_s[7]}}, lane8_s};
            store_word = word;
            store_word[{byte_sel, 3'b000} +: 8] = store_data[7:0];
         end
         SZ_HALF: begin
            load_val   = {{16{sign_ext & lane16_s[15]}}, lane16_s};
            store_word = word;
            store_word[{byte_sel[1], 4'b0000} +: 16] = store_data[15:0];
         end
         default: begin
            load_val   = word;
            store_word = store_data;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the datapath memory stage and a word-addressed
// data memory; sub-word stores run as a two-cycle read-modify-write.
module load_store_unit
   import mips_defs::*;
#(
   parameter int DMEM_DEPTH = 100
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   localparam logic [29:0] DEPTH_IDX = 30'(DMEM_DEPTH);

   lsu_state_t  state_r, next_s;
   lsu_op_t     op_s;
   logic [29:0] req_idx_s;
   logic        req_err_s;
   logic        accept_s;
   logic        sub_store_s;

   logic [29:0] wr_idx_r;
   logic [31:0] wr_word_r;
   logic [31:0] wr_data_r;
   logic [1:0]  wr_sel_r;
   lsu_size_t   wr_size_r;

   logic [31:0] mrg_word_s;
   logic [1:0]  mrg_sel_s;
   lsu_size_t   mrg_size_s;
   logic [31:0] mrg_data_s;
   logic [31:0] load_val_s;
   logic [31:0] store_word_s;

   assign op_s        = lsu_op_t'(req_op);
   assign req_idx_s   = req_addr[31:2];
   assign req_err_s   = op_misaligned(op_s, req_addr[1:0]) || (req_idx_s >= DEPTH_IDX);
   assign accept_s    = (state_r == ST_IDLE) && req_valid;
   assign sub_store_s = (op_s == OP_SH) || (op_s == OP_SB);
   assign req_ready   = (state_r == ST_IDLE);

   // In WRITE the merger works on the captured word; otherwise on the live read
   always_comb begin
      if (state_r == ST_WRITE) begin
         mrg_word_s = wr_word_r;
         mrg_sel_s  = wr_sel_r;
         mrg_size_s = wr_size_r;
         mrg_data_s = wr_data_r;
      end else begin
         mrg_word_s = mem_rd;
         mrg_sel_s  = req_addr[1:0];
         mrg_size_s = op_size(op_s);
         mrg_data_s = req_wdata;
      end
   end

   lsu_lane_merge u_lane_merge (
      .word       (mrg_word_s),
      .byte_sel   (mrg_sel_s),
      .size       (mrg_size_s),
      .sign_ext   (op_signed(op_s)),
      .store_data (mrg_data_s),
      .load_val   (load_val_s),
      .store_word (store_word_s)
   );

   // next-state and memory-port decode; erroneous requests never touch memory
   always_comb begin
      next_s   = state_r;
      mem_addr = 32'h0000_0000;
      mem_wd   = 32'h0000_0000;
      mem_we   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (req_err_s) begin
                  next_s = ST_RESP;
               end else begin
                  mem_addr = {2'b00, req_idx_s};
                  if (op_s == OP_SW) begin
                     mem_we = 1'b1;
                     mem_wd = req_wdata;
                     next_s = ST_RESP;
                  end else if (sub_store_s) begin
                     next_s = ST_WRITE;
                  end else begin
                     next_s = ST_RESP;
                  end
               end
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            mem_addr = {2'b00, wr_idx_r};
            mem_wd   = store_word_s;
            mem_we   = 1'b1;
            next_s   = ST_RESP;
         end
         ST_RESP: begin
            next_s = ST_IDLE;
         end
         default: begin
            next_s = ST_IDLE;
         end
      endcase
   end

   // state and response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0000_0000;
      end else begin
         state_r    <= next_s;
         resp_valid <= (next_s == ST_RESP);
         if (accept_s) begin
            resp_err   <= req_err_s;
            resp_rdata <= (req_err_s || op_is_store(op_s)) ? 32'h0000_0000 : load_val_s;
         end
      end
   end

   // capture for the read-modify-write of SH/SB
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_idx_r  <= 30'h0;
         wr_word_r <= 32'h0000_0000;
         wr_data_r <= 32'h0000_0000;
         wr_sel_r  <= 2'b00;
         wr_size_r <= SZ_BYTE;
      end else if (accept_s && !req_err_s && sub_store_s) begin
         wr_idx_r  <= req_idx_s;
         wr_word_r <= mem_rd;
         wr_data_r <= req_wdata;
         wr_sel_r  <= req_addr[1:0];
         wr_size_r <= op_size(op_s);
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-level reference model predicts
// every response and memory write; literal values pin the model.
module tb_load_store_unit;

   localparam int DEPTH = 100;
   localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                          LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

   typedef struct {
      logic        err;
      logic [31:0] rd;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   logic [31:0] dmem    [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];
   logic        mem_init = 1'b1;
   resp_t       exp_q[$];
   resp_t       cmp_e;
   logic        prev_rv = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] saved5;

   load_store_unit #(.DMEM_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pattern(input int i);
      return 32'(i) * 32'h0103_0507 + 32'h1020_3040;
   endfunction

   assign mem_rd = (mem_addr < 32'd100) ? dmem[mem_addr[6:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) dmem[i] <= pattern(i);
      end else if (mem_we && mem_addr < 32'd100) begin
         dmem[mem_addr[6:0]] <= mem_wd;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Reference model: byte-lane arithmetic on ref_mem; updates it for stores.
   function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic err,
                                 output logic [31:0] rd, output logic [31:0] new_word);
      int unsigned idx = addr >> 2;
      int unsigned off = addr % 4;
      logic [31:0] w, lane, mask;
      err = 1'b0;
      rd = 32'h0;
      new_word = 32'h0;
      if (op == LW || op == SW) err = (off != 0);
      else if (op == LH || op == LHU || op == SH) err = (off % 2 != 0);
      if (idx >= DEPTH) err = 1'b1;
      if (err) return;
      w = ref_mem[idx];
      case (op)
         LW: rd = w;
         LH, LHU: begin
            lane = (w >> (8 * off)) & 32'hFFFF;
            rd = (op == LH && lane >= 32'h8000) ? lane + 32'hFFFF_0000 : lane;
         end
         LB, LBU: begin
            lane = (w >> (8 * off)) & 32'hFF;
            rd = (op == LB && lane >= 32'h80) ? lane + 32'hFFFF_FF00 : lane;
         end
         SW: begin
            new_word = wd;
            ref_mem[idx] = wd;
         end
         SH: begin
            mask = 32'hFFFF << (8 * off);
            new_word = (w & ~mask) | ((wd & 32'hFFFF) << (8 * off));
            ref_mem[idx] = new_word;
         end
         default: begin
            mask = 32'hFF << (8 * off);
            new_word = (w & ~mask) | ((wd & 32'hFF) << (8 * off));
            ref_mem[idx] = new_word;
         end
      endcase
   endfunction

   // Response checker: every resp_valid pulse must match the next expected response.
   always @(negedge clk) begin
      if (rst) begin
         if (resp_valid) begin
            chk1("resp_single_pulse", prev_rv, 1'b0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_resp: got resp_valid=1 expected none (t=%0t)", $time);
            end else begin
               cmp_e = exp_q.pop_front();
               chk("resp_rdata", resp_rdata, cmp_e.rd);
               chk1("resp_err", resp_err, cmp_e.err);
            end
         end
         prev_rv = resp_valid;
      end else begin
         prev_rv = 1'b0;
      end
   end

   // Issue one request at an idle cycle (called #1 after a posedge) and walk it to completion.
   task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] lit_rd, input logic lit_err, input bit use_lit);
      logic err, sub;
      logic [31:0] rd, nw;
      resp_t e;
      model(op, addr, wd, err, rd, nw);
      if (use_lit) begin
         chk("model_rdata", rd, lit_rd);
         chk1("model_err", err, lit_err);
      end
      sub = !err && (op == SH || op == SB);
      e.err = err;
      e.rd = rd;
      exp_q.push_back(e);
      req_valid = 1'b1;
      req_op = op;
      req_addr = addr;
      req_wdata = wd;
      @(negedge clk);
      chk1("accept_ready", req_ready, 1'b1);
      chk1("accept_we", mem_we, !err && op == SW);
      chk("accept_addr", mem_addr, err ? 32'h0 : addr >> 2);
      if (!err && op == SW) chk("accept_wd", mem_wd, wd);
      @(posedge clk);
      #1;
      req_op = LW;
      req_addr = 32'h4;
      if (sub) begin
         @(negedge clk);
         chk1("write_ready", req_ready, 1'b0);
         chk1("write_rv", resp_valid, 1'b0);
         chk1("write_we", mem_we, 1'b1);
         chk("write_addr", mem_addr, addr >> 2);
         chk("write_wd", mem_wd, nw);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk1("resp_rv", resp_valid, 1'b1);
      chk1("resp_ready", req_ready, 1'b0);
      chk1("resp_we", mem_we, 1'b0);
      if (use_lit) begin
         chk("lit_rdata", resp_rdata, lit_rd);
         chk1("lit_err", resp_err, lit_err);
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);
      #12;
      chk1("rst_ready", req_ready, 1'b1);
      chk1("rst_rv", resp_valid, 1'b0);
      chk1("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wd", mem_wd, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk1("rst_err", resp_err, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      mem_init = 1'b0;
      @(posedge clk);
      #1;

      issue(SW,  32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
      issue(LW,  32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      issue(LB,  32'hB, 32'h0, 32'hFFFF_FFDE, 1'b0, 1'b1);
      issue(LBU, 32'hB, 32'h0, 32'h0000_00DE, 1'b0, 1'b1);
      issue(LH,  32'h8, 32'h0, 32'hFFFF_BEEF, 1'b0, 1'b1);
      issue(LHU, 32'hA, 32'h0, 32'h0000_DEAD, 1'b0, 1'b1);
      issue(SB,  32'h9, 32'hAAAA_AA55, 32'h0, 1'b0, 1'b1);
      issue(SH,  32'hA, 32'hBBBB_1234, 32'h0, 1'b0, 1'b1);
      chk("word2_merged", dmem[2], 32'h1234_55EF);
      issue(LW,  32'h8, 32'h0, 32'h1234_55EF, 1'b0, 1'b1);

      issue(LW,  32'h6,   32'h0, 32'h0, 1'b1, 1'b1);
      issue(SH,  32'h3,   32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
      issue(SW,  32'h190, 32'h1111_1111, 32'h0, 1'b1, 1'b1);
      issue(LB,  32'h190, 32'h0, 32'h0, 1'b1, 1'b1);
      issue(LHU, 32'h21,  32'h0, 32'h0, 1'b1, 1'b1);

      issue(SW,  32'h18C, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
      issue(LW,  32'h18C, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      issue(SB,  32'h18F, 32'h0000_00AB, 32'h0, 1'b0, 1'b1);
      issue(LH,  32'h18E, 32'h0, 32'hFFFF_ABFE, 1'b0, 1'b1);
      issue(LHU, 32'h18E, 32'h0, 32'h0000_ABFE, 1'b0, 1'b1);
      issue(LBU, 32'h18D, 32'h0, 32'h0000_00F0, 1'b0, 1'b1);
      issue(LB,  32'h18C, 32'h0, 32'h0000_000D, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         issue(SB, 32'h40 + 32'(i), 32'h80 + 32'(i), 32'h0, 1'b0, 1'b0);
         issue(LB, 32'h40 + 32'(i), 32'h0, 32'h0, 1'b0, 1'b0);
      end
      issue(SH,  32'h52, 32'h0000_8001, 32'h0, 1'b0, 1'b0);
      issue(LH,  32'h52, 32'h0, 32'h0, 1'b0, 1'b0);

      saved5 = dmem[5];
      req_valid = 1'b1;
      req_op = SB;
      req_addr = 32'h14;
      req_wdata = 32'h0000_0077;
      @(negedge clk);
      chk1("rstw_accept_ready", req_ready, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk1("rstw_in_write", mem_we, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      chk1("rstw_we", mem_we, 1'b0);
      chk1("rstw_rv", resp_valid, 1'b0);
      chk1("rstw_ready", req_ready, 1'b1);
      chk("rstw_addr", mem_addr, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("rstw_no_resp", resp_valid, 1'b0);
         chk1("rstw_ready_after", req_ready, 1'b1);
      end
      chk("rstw_word5", dmem[5], saved5);
      @(posedge clk);
      #1;
      issue(LBU, 32'h14, 32'h0, 32'h0, 1'b0, 1'b0);

      for (int i = 0; i < DEPTH; i++) chk($sformatf("final_word%0d", i), dmem[i], ref_mem[i]);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the single-cycle datapath's memory stage and the word-addressed data memory. It accepts one load or store request at a time, converts byte addresses to word indices, and extracts with sign or zero extension on byte/halfword loads. Sub-word stores are done as a two-cycle read-modify-write. The unit stalls the datapath via `req_ready` and flags misaligned or out-of-range accesses instead of touching memory.

## Interface
Parameters:
- `DMEM_DEPTH`, 100, number of 32-bit words in the data memory; valid word index range is 0..DMEM_DEPTH-1.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, asynchronous, active-low reset.
- `req_valid`, in, 1, request present this cycle.
- `req_ready`, out, 1, unit accepts a request this cycle; request is taken when `req_valid && req_ready`.
- `req_op`, in, 3, operation: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- `req_addr`, in, 32, byte address.
- `req_wdata`, in, 32, store data; SB uses [7:0], SH uses [15:0].
- `resp_valid`, out, 1, one-cycle pulse when the request completes.
- `resp_rdata`, out, 32, load result; 0 for stores and errors.
- `resp_err`, out, 1, valid with `resp_valid`; set for misaligned or out-of-range requests.
- `mem_addr`, out, 32, word index to the data memory, equal to `{2'b00, addr[31:2]}`.
- `mem_wd`, out, 32, write data to the data memory.
- `mem_we`, out, 1, write enable to the data memory.
- `mem_rd`, in, 32, combinational read data from the data memory at `mem_addr`.

## Operation
- Byte lanes are little-endian. `addr[1:0]`=0 selects bits [7:0], and 3 selects bits [31:24]. For halfwords, `addr[1]`=0 selects bits [15:0].
- A request is misaligned when:
  - LW or SW has `addr[1:0]` != 0.
  - LH, LHU or SH has `addr[0]` = 1.
- A request is out of range when `addr[31:2]` >= DMEM_DEPTH.
- An erroneous request never asserts `mem_we`.
- The FSM has three states: IDLE, WRITE and RESP.
- IDLE:
  - `req_ready`=1.
  - On accept, `mem_addr` is driven combinationally from `req_addr`.
  - Error: register `resp_err`=1 and `resp_rdata`=0, then go to RESP.
  - Load: register the extracted or extended lane of `mem_rd` into `resp_rdata`, then go to RESP.
  - SW: assert `mem_we`=1 and `mem_wd`=`req_wdata` in the same cycle, then go to RESP.
  - SH or SB: capture the word index, `mem_rd` and the store lane data into internal registers, then go to WRITE.
- WRITE:
  - `req_ready`=0.
  - `mem_addr` is the saved index and `mem_we`=1.
  - `mem_wd` is the captured word with only the target byte or halfword replaced.
  - Go to RESP.
- RESP:
  - `req_ready`=0 and `resp_valid`=1.
  - `resp_rdata` and `resp_err` hold their registered values.
  - Go to IDLE.
- Any time the unit does not drive a memory access, `mem_addr`=0, `mem_wd`=0 and `mem_we`=0.
- Sign extension:
  - LB replicates bit 7 of the lane.
  - LH replicates bit 15 of the lane.
  - LBU and LHU zero-fill.

## Timing
- Reset (async, `rst`=0):
  - State goes to IDLE.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wd`=0.
  - `req_ready`=1 once in IDLE.
- Latency from accept to `resp_valid`:
  - Loads, SW and errors: 1 cycle.
  - SH and SB: 2 cycles.
- Throughput:
  - Loads, SW and errors: one request every 2 cycles.
  - SH and SB: one request every 3 cycles.
- The memory write commits on the clock edge at the end of the IDLE cycle (SW) or the WRITE cycle (SH/SB).
- `req_valid` is ignored while `req_ready`=0. The datapath holds its request and stalls.
- Reset asserted during WRITE: the sub-word write is abandoned, no `mem_we` is issued, and no response is produced.
- Reset asserted during RESP: the response is dropped.
- A request at the last word (index DMEM_DEPTH-1) is legal. A request at index DMEM_DEPTH is out of range.
- `resp_valid` never stays high for two consecutive cycles.

## Structure
- A shared constants file `mips_defs` holds:
  - The 3-bit `req_op` encodings (LW..SB).
  - The FSM state encodings IDLE=0, WRITE=1, RESP=2.
- One sub-module, `lsu_lane_merge`, is purely combinational. Given the word, `addr[1:0]`, size and signedness, it produces:
  - the extended load value;
  - the merged store word.
- `load_store_unit` owns the FSM, the registers and the error checks.

## Test plan
- After reset, check outputs idle: `req_ready`=1, `resp_valid`=0, `mem_we`=0, `mem_addr`=0.
- SW at addr 0x8, data 0xDEADBEEF:
  - `mem_we`=1 with `mem_addr`=2 in the accept cycle.
  - `resp_valid`=1, `resp_err`=0 the next cycle.
  - A subsequent LW at 0x8 returns 0xDEADBEEF.
- With word 2 = 0xDEADBEEF, loads return:
  - LB at 0xB: 0xFFFFFFDE.
  - LBU at 0xB: 0x000000DE.
  - LH at 0x8: 0xFFFFBEEF.
  - LHU at 0xA: 0x0000DEAD.
- SB 0x55 at 0x9, then SH 0x1234 at 0xA:
  - Each takes 2 cycles to respond, with `mem_we` only in the WRITE cycle.
  - Word 2 ends as 0x12345.5EF... specifically 0x123455EF.
- Error cases each give `resp_err`=1 after 1 cycle, with `mem_we` never asserted:
  - LW at 0x6 (misaligned).
  - SH at 0x3 (misaligned).
  - SW at 0x190 (index 100, out of range).
- Assert `rst` during the WRITE cycle of an SB to word 5: word 5 is unchanged, no `resp_valid` is produced, and `req_ready`=1 after reset releases.
